// File: rtl/c17_stim_pkg.sv
// c17_stim_pkg: shared types, constants and LFSR step for the c17 stimulus generator.
package c17_stim_pkg;
  typedef enum logic [1:0] {IDLE, APPLY, HOLD, DONE} state_t;
  localparam logic [15:0] LFSR_MASK = 16'hA011;
  localparam int IDX_NX1 = 0;
  localparam int IDX_NX7 = 1;
  localparam int IDX_NX3 = 2;
  localparam int IDX_NX2 = 3;
  localparam int IDX_NX6 = 4;
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], 1'b0} ^ (s[15] ? LFSR_MASK : 16'h0000);
  endfunction
endpackage

// File: rtl/c17_lfsr.sv
// c17_lfsr: Galois LFSR with seed load (zero seed replaced by SEED) and advance enable.
module c17_lfsr import c17_stim_pkg::*; #(
  parameter int LFSR_W = 16,
  parameter logic [LFSR_W-1:0] SEED = 16'h0001
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              adv,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] nxt
);
  logic [LFSR_W-1:0] value, base;
  // a same-cycle load feeds the step so the run starts from the fresh seed
  assign base = load ? (seed == '0 ? SEED : seed) : value;
  assign nxt = lfsr_step(base);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) value <= SEED;
    else value <= adv ? nxt : base;
endmodule

// File: rtl/c17_stim_gen.sv
// c17_stim_gen: applies LFSR vectors to the c17 PIs, each held for gap+1 cycles.
module c17_stim_gen import c17_stim_pkg::*; #(
  parameter int WIDTH = 5,
  parameter int LFSR_W = 16,
  parameter int CNT_W = 16,
  parameter int GAP_W = 8,
  parameter logic [LFSR_W-1:0] SEED = 16'h0001
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_vec,
  input  logic [GAP_W-1:0]  gap,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed,
  output logic [WIDTH-1:0]  vec_out,
  output logic              vec_valid,
  output logic [CNT_W-1:0]  vec_cnt,
  output logic              busy,
  output logic              done
);
  state_t state;
  logic [CNT_W-1:0] num_q;
  logic [GAP_W-1:0] gap_q, hold_cnt;
  logic [LFSR_W-1:0] nxt;
  logic go, fin, load;
  assign load = seed_load && state == IDLE;
  assign fin = vec_cnt == num_q;
  // go marks the edge that makes a new vector visible in the following cycle
  assign go = (state == IDLE && start && num_vec != '0) ||
              (state == APPLY && gap_q == '0 && !fin) ||
              (state == HOLD && hold_cnt == GAP_W'(1) && !fin);
  c17_lfsr #(.LFSR_W(LFSR_W), .SEED(SEED)) u_lfsr (
    .clk(clk), .rst_n(rst_n), .load(load), .adv(go), .seed(seed), .nxt(nxt)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      num_q <= '0;
      gap_q <= '0;
      hold_cnt <= '0;
      vec_out <= '0;
      vec_valid <= 1'b0;
      vec_cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      vec_valid <= go;
      done <= 1'b0;
      if (go) begin
        state <= APPLY;
        vec_out <= nxt[WIDTH-1:0];
        busy <= 1'b1;
        vec_cnt <= state == IDLE ? CNT_W'(1) : vec_cnt + CNT_W'(1);
      end
      case (state)
        IDLE: if (start) begin
          num_q <= num_vec;
          gap_q <= gap;
          if (num_vec == '0) begin
            vec_cnt <= '0;
            state <= DONE;
            done <= 1'b1;
          end
        end
        APPLY: if (gap_q != '0) begin
          hold_cnt <= gap_q;
          state <= HOLD;
        end else if (fin) begin
          state <= DONE;
          done <= 1'b1;
          busy <= 1'b0;
        end
        HOLD: begin
          hold_cnt <= hold_cnt - GAP_W'(1);
          if (hold_cnt == GAP_W'(1) && fin) begin
            state <= DONE;
            done <= 1'b1;
            busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule
